// File: rtl/proc_pkg.sv
// Shared definitions for the operand/writeback word selector: select-mode
// encodings and a bounded clog2 usable in parameter expressions.
package proc_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Returns at least 1 so a 2-input selector still gets a 1-bit index.
  function automatic int clog2_safe(input int n);
    int w;
    w = 5;
    for (int i = 5; i >= 1; i--) begin
      if ((1 << i) >= n) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Round-robin scan pointer that wraps at N_IN-1; clr forces the pointer to
// zero in the same cycle so a capture on that cycle already uses index 0.
module mux_scan_ctr #(
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             clr,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cnt_q;

  assign idx = clr ? '0 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (adv) begin
      cnt_q <= (int'(idx) == N_IN - 1) ? '0 : idx + SEL_W'(1);
    end else if (clr) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 word selector with valid/ready flow control and a
// direct or round-robin scan select source.
module mux_nto1_pipe
  import proc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 8,
  localparam int SEL_W = clog2_safe(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  sel_err
);

  // Handshake: a word moves on either side only when valid && ready are both
  // high at a rising edge; in_ready never looks at in_valid, and a stalled
  // out_data/out_valid pair holds until out_ready is seen.
  logic             mode_q;
  logic             mode_edge;
  logic             capture;
  logic [SEL_W-1:0] cur_idx;
  logic             idx_ok;
  logic [WIDTH-1:0] word;

  assign in_ready  = enable && (!out_valid || out_ready);
  assign capture   = in_valid && in_ready;
  assign mode_edge = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
  assign cur_idx   = (mode == MODE_SCAN) ? scan_idx : sel;
  assign idx_ok    = int'(cur_idx) < N_IN;

  mux_scan_ctr #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_scan_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (capture && (mode == MODE_SCAN)),
    .clr   (mode_edge),
    .idx   (scan_idx)
  );

  // Out-of-range indices match no slot and fall through to zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(cur_idx) == i) word = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
    end else begin
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (capture) begin
      out_data  <= idx_ok ? word : '0;
      out_valid <= 1'b1;
      sel_err   <= !idx_ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
